// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional packet locking is enabled by defining UART_TX_ARBITER_LOCK_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
`ifdef UART_TX_ARBITER_LOCK_EN
    input  logic [NUM_REQ-1:0]     req_lock_i,
`endif
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             uart_data_o,
    output logic                   uart_write_o,
    input  logic                   uart_busy_i,
    output logic                   timeout_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StWrite, StWaitBusy, StWaitDone} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [7:0]        data_q;
    logic              write_q;
    logic              timeout_q;
`ifdef UART_TX_ARBITER_LOCK_EN
    logic              lock_q;
`endif

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] win_onehot;
    logic               win_found;
    logic [IdxW-1:0]    win_idx;
    logic [7:0]         win_data;
    logic               accept;

    always_comb begin
        int unsigned cand;
        cand      = 0;
        eligible  = req_valid_i;
`ifdef UART_TX_ARBITER_LOCK_EN
        // While locked only the owner may win, even if it currently has nothing to send.
        if (lock_q && req_lock_i[ptr_q]) begin
            eligible = req_valid_i & (NUM_REQ'(1) << ptr_q);
        end
`endif
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!win_found && eligible[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
        win_data = 8'h00;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IdxW'(i) == win_idx) begin
                win_data = req_data_i[8*i +: 8];
            end
        end
    end

    assign accept      = reset_i && (state_q == StIdle) && !uart_busy_i && win_found;
    assign win_onehot  = NUM_REQ'(1) << win_idx;
    assign req_ready_o = accept ? win_onehot : '0;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= StIdle;
            ptr_q     <= IdxW'(NUM_REQ - 1);
            cnt_q     <= '0;
            grant_q   <= '0;
            data_q    <= 8'h00;
            write_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            write_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
`ifdef UART_TX_ARBITER_LOCK_EN
                    if (lock_q && !req_lock_i[ptr_q]) begin
                        lock_q <= 1'b0;
                    end
`endif
                    if (accept) begin
                        data_q  <= win_data;
                        grant_q <= win_onehot;
                        ptr_q   <= win_idx;
                        write_q <= 1'b1;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    cnt_q   <= '0;
                    state_q <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (uart_busy_i) begin
                        state_q <= StWaitDone;
                    end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
                        // Byte is dropped; the transmitter never acknowledged it.
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                        state_q   <= StIdle;
`ifdef UART_TX_ARBITER_LOCK_EN
                        lock_q    <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!uart_busy_i) begin
                        grant_q <= '0;
                        state_q <= StIdle;
`ifdef UART_TX_ARBITER_LOCK_EN
                        lock_q  <= req_lock_i[ptr_q];
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign uart_data_o  = data_q;
    assign uart_write_o = write_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter busy model.
// Define UART_TX_ARBITER_LOCK_EN to also exercise packet locking.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned BUSY_TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  uart_data;
    logic        uart_write;
    logic        uart_busy;
    logic        timeout;

    int          errors = 0;
    int          checks = 0;
    int          busy_len = 20;
    logic [11:0] strobes[$];

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset_n),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
`ifdef UART_TX_ARBITER_LOCK_EN
        .req_lock_i   (req_lock),
`endif
        .req_ready_o  (req_ready),
        .grant_o      (grant),
        .uart_data_o  (uart_data),
        .uart_write_o (uart_write),
        .uart_busy_i  (uart_busy),
        .timeout_o    (timeout)
    );

    // Transmitter model: busy rises the cycle after a strobe and stays high busy_len cycles.
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(posedge clock);
            if (uart_write && busy_len > 0) begin
                #1 uart_busy = 1'b1;
                repeat (busy_len) @(posedge clock);
                #1 uart_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (uart_write) strobes.push_back({grant, uart_data});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_strobes(input int n);
        for (int i = 0; i < 400 && strobes.size() < n; i++) @(negedge clock);
        check("strobe_count", strobes.size(), n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && grant != 4'b0000; i++) @(negedge clock);
        check("idle_grant", {28'd0, grant}, 32'd0);
    endtask

    task automatic wait_write();
        for (int i = 0; i < 40 && !uart_write; i++) @(negedge clock);
        check("write_seen", {31'd0, uart_write}, 32'd1);
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        req_lock  = 4'b0000;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_data", {24'd0, uart_data}, 32'd0);
        check("rst_write", {31'd0, uart_write}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);

        // Single byte from requester 0, busy held 20 cycles
        reset_n   = 1'b1;
        req_valid = 4'b0001;
        req_data  = 32'h0000_0041;
        #1 check("t1_ready", {28'd0, req_ready}, 32'h1);
        @(negedge clock);
        check("t1_write", {31'd0, uart_write}, 32'd1);
        check("t1_data", {24'd0, uart_data}, 32'h41);
        check("t1_grant", {28'd0, grant}, 32'h1);
        check("t1_ready_low", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0000;
        n = 0;
        while (n < 60 && grant != 4'b0000) begin
            @(negedge clock);
            n++;
        end
        check("t1_done_cycles", n, 22);
        check("t1_grant_clear", {28'd0, grant}, 32'd0);

        // Fresh pointer, all valid: rotation 0,1,2,3,0
        @(negedge clock) reset_n = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        strobes.delete();
        busy_len  = 2;
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        wait_strobes(5);
        req_valid = 4'b0000;
        for (int i = 0; i < 5 && i < strobes.size(); i++) begin
            check("t2_strobe", {20'd0, strobes[i]}, {20'd0, 4'b0001 << (i % 4), 8'h10 + 8'(i % 4)});
        end
        wait_idle();
        strobes.delete();

        // Lone requester 2 wins every round
        req_data  = 32'h13A2_1110;
        req_valid = 4'b0100;
        wait_strobes(3);
        req_valid = 4'b0000;
        for (int i = 0; i < 3 && i < strobes.size(); i++) begin
            check("t3_strobe", {20'd0, strobes[i]}, {20'd0, 12'h4A2});
        end
        wait_idle();
        strobes.delete();

        // Busy never asserts: timeout 16 cycles after the strobe, then requester 1 granted
        busy_len  = 0;
        req_data  = 32'h0000_6655;
        req_valid = 4'b0011;
        wait_write();
        check("t4_data", {24'd0, uart_data}, 32'h55);
        n = 0;
        while (n < 40 && !timeout) begin
            @(negedge clock);
            n++;
        end
        check("t4_timeout_cycles", n, 16);
        check("t4_grant_clear", {28'd0, grant}, 32'd0);
        check("t4_next_ready", {28'd0, req_ready}, 32'h2);
        busy_len = 2;
        @(negedge clock);
        check("t4_timeout_pulse", {31'd0, timeout}, 32'd0);
        check("t4_next_write", {31'd0, uart_write}, 32'd1);
        check("t4_next_data", {24'd0, uart_data}, 32'h66);
        req_valid = 4'b0000;
        wait_idle();
        strobes.delete();

        // Reset during WRITE drops the strobe immediately; requester 0 wins afterwards
        req_data  = 32'h1312_1110;
        req_valid = 4'b0100;
        wait_write();
        #1 reset_n = 1'b0;
        #1;
        check("t5_write_async", {31'd0, uart_write}, 32'd0);
        check("t5_grant_async", {28'd0, grant}, 32'd0);
        check("t5_data_async", {24'd0, uart_data}, 32'd0);
        check("t5_ready_in_rst", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b1111;
        @(negedge clock) reset_n = 1'b1;
        #1 check("t5_ready_after", {28'd0, req_ready}, 32'h1);
        @(negedge clock);
        check("t5_data_after", {24'd0, uart_data}, 32'h10);
        req_valid = 4'b0000;
        wait_idle();
        strobes.delete();

`ifdef UART_TX_ARBITER_LOCK_EN
        // Requester 1 locks for three bytes, then requester 2 follows
        req_lock  = 4'b0010;
        req_valid = 4'b1111;
        wait_strobes(3);
        req_lock  = 4'b0000;
        wait_strobes(4);
        req_valid = 4'b0000;
        for (int i = 0; i < 4 && i < strobes.size(); i++) begin
            check("t6_strobe", {20'd0, strobes[i]}, (i < 3) ? 32'h211 : 32'h412);
        end
        wait_idle();
        strobes.delete();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
